// File: rtl/seven_segment_scanner_pkg.sv
// Purpose: shared constants, scan FSM state type and hex font for the seven-segment scanner.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF    = 7'h7F;  // all segments dark (active-low)
    localparam logic [3:0] DSEL_OFF   = 4'hF;   // no digit selected (active-low)

    // Per-slot display phase: dark guard interval, then the digit is driven.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Hex font, bit order {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Purpose: load handshake bundle (valid/ready plus display word and digit-enable mask).
// Latency: n/a (wires only).
// Backpressure: load_ready low holds the producer off until the shadow buffer drains.
interface seven_segment_scanner_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;  // digit0 = [3:0] ... digit3 = [15:12]
    logic [3:0]  load_en;    // bit i enables digit i

    modport master (output load_valid, output load_data, output load_en, input  load_ready);
    modport slave  (input  load_valid, input  load_data, input  load_en, output load_ready);
endinterface

// File: rtl/seven_segment_scanner_hex_to_seg.sv
// Purpose: combinational hex nibble to active-low {g..a} segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: nibble (4-bit in), seg (7-bit out, active-low).
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = hex_font(nibble);
endmodule

// File: rtl/seven_segment_scanner.sv
// Purpose: 4-digit multiplexed seven-segment driver with double-buffered display word.
// Latency: word accepted in frame N shows from frame N+1; seg/numsl lag the slot counter by 1 cycle.
// Backpressure: load_ready drops after a transfer and rises the cycle after the frame boundary.
// Ports: clk, rst_n (async active-low), load_if (slave: load_valid/ready/data/en),
//        seg (active-low {g..a}), numsl (active-low digit selects), frame_done (1-cycle pulse).
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    seven_segment_scanner_if.slave    load_if,
    output logic [6:0]                seg,
    output logic [3:0]                numsl,
    output logic                      frame_done
);
    localparam int              CW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(PRESCALE - 1);
    localparam scan_state_e     ST_RESET = (BLANK > 0) ? ST_BLANK : ST_SHOW;

    logic [CW-1:0] count_q, count_d;
    logic [1:0]    idx_q, idx_d;
    scan_state_e   state_q, state_d;
    logic [15:0]   shadow_data_q, shadow_data_d;
    logic [3:0]    shadow_en_q, shadow_en_d;
    logic          shadow_full_q, shadow_full_d;
    logic [15:0]   active_data_q, active_data_d;
    logic [3:0]    active_en_q, active_en_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    numsl_q, numsl_d;
    logic          frame_done_q, frame_done_d;

    logic          boundary;
    logic          transfer;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_font;

    assign cur_nib = active_data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_font (
        .nibble (cur_nib),
        .seg    (cur_font)
    );

    always_comb begin
        count_d       = count_q;
        idx_d         = idx_q;
        state_d       = state_q;
        shadow_data_d = shadow_data_q;
        shadow_en_d   = shadow_en_q;
        shadow_full_d = shadow_full_q;
        active_data_d = active_data_q;
        active_en_d   = active_en_q;
        seg_d         = SEG_OFF;
        numsl_d       = DSEL_OFF;

        boundary     = (idx_q == 2'd3) && (count_q == CNT_LAST);
        transfer     = load_if.load_valid && !shadow_full_q;
        frame_done_d = boundary;

        if (count_q == CNT_LAST) begin
            count_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            count_d = count_q + 1'b1;
        end

        // State is computed from the next count so state_q always matches count_q.
        state_d = (int'(count_d) < BLANK) ? ST_BLANK : ST_SHOW;

        // Transfer and swap are exclusive: a transfer needs the shadow empty, a swap needs it full.
        // A transfer on the boundary therefore only fills the shadow for the next frame.
        if (transfer) begin
            shadow_data_d = load_if.load_data;
            shadow_en_d   = load_if.load_en;
            shadow_full_d = 1'b1;
        end else if (boundary && shadow_full_q) begin
            active_data_d = shadow_data_q;
            active_en_d   = shadow_en_q;
            shadow_full_d = 1'b0;
        end

        if ((state_q == ST_SHOW) && active_en_q[idx_q]) begin
            numsl_d = ~(4'b0001 << idx_q);
            seg_d   = cur_font;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            idx_q         <= 2'd0;
            state_q       <= ST_RESET;
            shadow_data_q <= 16'h0000;
            shadow_en_q   <= 4'h0;
            shadow_full_q <= 1'b0;
            active_data_q <= 16'h0000;
            active_en_q   <= 4'h0;
            seg_q         <= SEG_OFF;
            numsl_q       <= DSEL_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            count_q       <= count_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            shadow_full_q <= shadow_full_d;
            active_data_q <= active_data_d;
            active_en_q   <= active_en_d;
            seg_q         <= seg_d;
            numsl_q       <= numsl_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign load_if.load_ready = !shadow_full_q;
    assign seg                = seg_q;
    assign numsl              = numsl_q;
    assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Purpose: self-checking bench for seven_segment_scanner against a frame/time-based reference model.
// Latency: n/a.
// Backpressure: producer holds load_valid until the model says the word is accepted.
module tb_seven_segment_scanner;
    localparam int PRE   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 4 * PRE;

    // Hex font {g..a}, active-low.
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int          ta;   // cycle the word was accepted
        int          af;   // first frame in which the word is displayed
        logic [15:0] d;
        logic [3:0]  e;
    } word_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] numsl;
    logic       frame_done;

    int    checks   = 0;
    int    failures = 0;
    int    t        = 0;   // rising edges since reset release
    word_t words[$];

    seven_segment_scanner_if lif ();

    seven_segment_scanner #(.PRESCALE(PRE), .BLANK(BLK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_if    (lif),
        .seg        (seg),
        .numsl      (numsl),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h at t=%0d", tag, obs, exp, t);
        end
    endtask

    // Expected outputs at cycle t, derived from frame/slot arithmetic on the accepted-word log.
    function automatic void model(input int tc, output logic [6:0] s, output logic [3:0] n,
                                  output logic fd, output logic rdy);
        int          u;
        int          f;
        int          cnt;
        int          idx;
        logic [15:0] d;
        logic [3:0]  e;
        s   = 7'h7F;
        n   = 4'hF;
        fd  = 1'b0;
        rdy = 1'b1;
        foreach (words[i])
            if (words[i].ta < tc && tc < words[i].af * FRAME) rdy = 1'b0;
        if (tc == 0) return;
        u   = tc - 1;
        f   = u / FRAME;
        cnt = u % PRE;
        idx = (u / PRE) % 4;
        fd  = ((u % FRAME) == FRAME - 1);
        d   = 16'h0000;
        e   = 4'h0;
        foreach (words[i])
            if (words[i].af <= f) begin
                d = words[i].d;
                e = words[i].e;
            end
        if (cnt >= BLK && e[idx]) begin
            n      = 4'hF;
            n[idx] = 1'b0;
            s      = FONT[d[idx*4 +: 4]];
        end
    endfunction

    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] e, output logic acc);
        logic [6:0] es;
        logic [3:0] en_exp;
        logic       efd;
        logic       erdy;
        model(t, es, en_exp, efd, erdy);
        chk("seg", {9'd0, seg}, {9'd0, es});
        chk("numsl", {12'd0, numsl}, {12'd0, en_exp});
        chk("frame_done", {15'd0, frame_done}, {15'd0, efd});
        chk("load_ready", {15'd0, lif.load_ready}, {15'd0, erdy});
        lif.load_valid = v;
        lif.load_data  = d;
        lif.load_en    = e;
        acc = v && erdy;
        if (acc) words.push_back('{t, (t + 1) / FRAME + 1, d, e});
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, acc);
    endtask

    task automatic idle_until_phase(input int modulus, input int phase);
        logic acc;
        int   k;
        k = 0;
        while ((t % modulus) != phase && k < 200) begin
            step(1'b0, 16'h0000, 4'h0, acc);
            k++;
        end
        chk("phase_reached", {15'd0, ((t % modulus) == phase)}, 16'd1);
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] e);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 200) begin
            step(1'b1, d, e, acc);
            k++;
        end
        chk("send_accepted", {15'd0, acc}, 16'd1);
    endtask

    initial begin
        logic acc;
        rst_n          = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_data  = 16'h0000;
        lif.load_en    = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_numsl", {12'd0, numsl}, 16'h000F);
        chk("rst_frame_done", {15'd0, frame_done}, 16'd0);
        chk("rst_load_ready", {15'd0, lif.load_ready}, 16'd1);
        rst_n = 1'b1;
        t     = 0;

        // Dark display, frame_done every FRAME cycles.
        idle(64);

        // Single word mid-frame.
        idle_until_phase(FRAME, 10);
        send(16'h1234, 4'hF);
        idle(70);

        // Back-to-back words: the second is held off until the boundary drains the shadow.
        send(16'h1111, 4'hF);
        send(16'h2222, 4'hF);
        idle(80);

        // Word offered exactly on the boundary cycle.
        idle_until_phase(FRAME, FRAME - 1);
        step(1'b1, 16'hABCD, 4'hF, acc);
        chk("boundary_accept", {15'd0, acc}, 16'd1);
        idle(80);

        // Partial enable mask.
        send(16'h8888, 4'b0101);
        idle(80);

        // Randomised offers, including offers while not ready.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), acc);
            else
                step(1'b0, 16'h0000, 4'h0, acc);
        end
        idle(70);

        // Reset during a SHOW slot with the shadow full.
        send(16'h9876, 4'hF);
        idle(70);
        idle_until_phase(FRAME, 4);
        send(16'h5A5A, 4'hF);
        idle_until_phase(PRE, 5);
        chk("pre_reset_lit", {12'd0, numsl}, {12'd0, ~(4'b0001 << ((t - 1) / PRE % 4))});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", {9'd0, seg}, 16'h007F);
        chk("async_rst_numsl", {12'd0, numsl}, 16'h000F);
        chk("async_rst_frame_done", {15'd0, frame_done}, 16'd0);
        chk("async_rst_load_ready", {15'd0, lif.load_ready}, 16'd1);
        lif.load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst_seg", {9'd0, seg}, 16'h007F);
        chk("held_rst_numsl", {12'd0, numsl}, 16'h000F);
        rst_n = 1'b1;
        words.delete();
        t = 0;
        idle(96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter PRESCALE, default 1024: clk cycles per digit slot; legal range is at least 2.
REQ-002 SHALL have parameter BLANK, default 16: blanking cycles at the start of each slot; legal range is 0 to PRESCALE-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port load_valid  input  1  producer offers a new display word.
REQ-006 SHALL have port load_ready  output  1  shadow buffer empty, so the offered word is accepted this cycle.
REQ-007 SHALL have port load_data  input  16  four hex nibbles; digit0 = [3:0] ... digit3 = [15:12].
REQ-008 SHALL have port load_en  input  4  per-digit enable mask, bit i = digit i.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port numsl  output  4  digit selects, active-low, at most one low at a time.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Transfer SHALL occur on a cycle where load_valid and load_ready are both high; load_data and load_en SHALL then be captured into the shadow buffer and the shadow marked full.
REQ-013 load_ready SHALL equal NOT shadow_full (registered); a transfer SHALL drop it on the next cycle.
REQ-014 Slot counter SHALL count 0..PRESCALE-1, then wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-015 A frame SHALL be 4 slots (4*PRESCALE cycles). The frame boundary SHALL be the cycle with digit index 3 and count PRESCALE-1.
REQ-016 At the frame boundary, if the shadow is full, the active data and enable SHALL load from the shadow and the shadow SHALL empty; load_ready SHALL be high on the following cycle.
REQ-017 A transfer on the boundary cycle with the shadow empty SHALL fill the shadow only; the word SHALL become active at the next boundary.
REQ-018 The controller SHALL be a two-state FSM per slot: BLANK while count < BLANK, SHOW otherwise. With BLANK=0 the BLANK state SHALL never be entered.
REQ-019 In BLANK, numsl SHALL be 4'b1111 and seg SHALL be 7'b1111111.
REQ-020 In SHOW, numsl[idx] SHALL be 0 when active_en[idx]=1, and seg SHALL be the hex font of active nibble idx.
REQ-021 In SHOW with a disabled digit, numsl SHALL be 4'b1111 and seg SHALL be 7'b1111111.
REQ-022 Outputs seg and numsl SHALL be registered, one cycle after the count/idx that selects them.
REQ-023 Font SHALL cover 0-F: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110 ({g..a}, active-low).
REQ-024 frame_done SHALL be high exactly on the cycle after the boundary cycle, once per frame.
REQ-025 Latency: a word accepted during frame N SHALL first drive digit0 in frame N+1 at slot cycle BLANK+1.

Reset
REQ-026 While rst_n=0 the block SHALL hold: seg=7'h7F, numsl=4'hF, frame_done=0, load_ready=1, count=0, idx=0, active data=0, active_en=0, shadow empty.
REQ-027 Reset asserted mid-frame SHALL immediately blank the display and discard any shadow content.
REQ-028 After rst_n rises, the first frame SHALL start at idx 0, count 0, in BLANK when BLANK>0.

Structure
REQ-029 Shared package seg_pkg SHALL hold NUM_DIGITS=4, SEG_OFF=7'h7F, DSEL_OFF=4'hF, and the hex font function.
REQ-030 A single sub-module hex_to_seg SHALL be used: combinational nibble to 7-bit active-low pattern.
REQ-031 The scanner body SHALL contain the counter, FSM, shadow/active buffers, and output registers.

Verification (PRESCALE=8, BLANK=2 unless stated)
REQ-032 Reset release, no load -> numsl=4'hF and seg=7'h7F for 64 cycles; frame_done pulses every 32 cycles.
REQ-033 Load 16'h1234, en=4'hF mid-frame 0 -> frame 1 shows digit0 '4', digit1 '3', digit2 '2', digit3 '1'. Each select is low for 6 of 8 cycles; never more than one select low.
REQ-034 Two back-to-back loads, 16'h1111 then 16'h2222 -> the second load is held off by load_ready=0 until after the boundary. Frame 1 shows 1111, frame 2 shows 2222.
REQ-035 Load 16'hABCD presented exactly on the boundary cycle, shadow empty -> accepted, but not visible until the following frame.
REQ-036 en=4'b0101 with data 16'h8888 -> digits 0 and 2 show 7'b0000000; digits 1 and 3 stay dark.
REQ-037 Assert rst_n=0 during a SHOW slot with the shadow full -> outputs blank asynchronously; after release, no digit lights until a new load.
